// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and default constants for the run controller.
package run_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, RST, RUN, DRAIN, DONE} run_state_t;

    localparam int RST_CYCLES_DEF = 4;
    localparam int DRAIN_DEF      = 2;
    localparam int CW_DEF         = 16;
    localparam int TMO_DEF        = 16'hFFFF;

    function automatic int max2(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/run_ctrl_phase_timer.sv
// phase_timer: loadable down-counter with a zero flag, timing the RST and DRAIN phases.
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? val_i : (cnt_q == '0 ? cnt_q : cnt_q - 1'b1);

    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: sequences core reset, run, drain and a four-phase done handshake for one run.
// Optional watchdog ends a run after TMO cycles when RUN_CTRL_WATCHDOG_EN is defined.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int RST_CYCLES = RST_CYCLES_DEF,
    parameter int DRAIN      = DRAIN_DEF,
    parameter int CW         = CW_DEF,
    parameter int TMO        = TMO_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_en,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycle_cnt
);

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam int TW       = $clog2(max2(RST_CYCLES, DRAIN) + 1);
    localparam int DRAIN_LD = DRAIN > 0 ? DRAIN - 1 : 0;

    run_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic          core_reset_q, core_en_q, busy_q, done_q;
    logic          t_load, t_zero;
    logic [TW-1:0] t_val;

    phase_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .load_i (t_load),
        .val_i  (t_val),
        .zero_o (t_zero)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        t_load  = 1'b0;
        t_val   = TW'(RST_CYCLES - 1);
        case (state_q)
            IDLE: if (req) begin
                state_d = RST;
                cnt_d   = '0;
                tmo_d   = 1'b0;
                t_load  = 1'b1;
            end
            RST: if (t_zero) state_d = RUN;
            RUN: if (core_done) begin
                state_d = DRAIN == 0 ? DONE : run_ctrl_pkg::DRAIN;
                t_load  = 1'b1;
                t_val   = TW'(DRAIN_LD);
            end else if (WD_EN && cnt_q == CW'(TMO - 1)) begin
                state_d = DONE;
                cnt_d   = CW'(TMO);
                tmo_d   = 1'b1;
            end else if (cnt_q != '1) begin
                cnt_d   = cnt_q + 1'b1;
            end
            run_ctrl_pkg::DRAIN: if (t_zero) state_d = DONE;
            DONE: if (!req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tmo_q        <= 1'b0;
            core_reset_q <= 1'b1;
            core_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            core_reset_q <= state_d == IDLE || state_d == RST;
            core_en_q    <= state_d == RUN;
            busy_q       <= state_d == RST || state_d == RUN || state_d == run_ctrl_pkg::DRAIN;
            done_q       <= state_d == DONE;
        end

    assign core_reset = core_reset_q;
    assign core_en    = core_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = tmo_q;
    assign cycle_cnt  = cnt_q;

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller for the single-cycle processor core. Accepts a host `req`, holds the core in reset for a programmed number of cycles, releases it, counts execution cycles until the core signals program end, lets final stores retire, then reports `done` with a four-phase handshake. It sits between the testbench/host and the core's top level, driving the core's reset and clock-enable.

## Interface

**Parameters**

- `RST_CYCLES`, default 4: cycles `core_reset` is held after a run starts; must be ≥1.
- `DRAIN`, default 2: cycles the core is frozen after `core_done` before `done` rises; 0 is legal.
- `CW`, default 16: width of `cycle_cnt`.
- `TMO`, default 16'hFFFF: watchdog limit in run cycles; 1 ≤ `TMO` ≤ 2^CW−1. Used only with `RUN_CTRL_WATCHDOG_EN`.

**Ports**

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req` input 1: host run request, level-sensitive.
- `core_done` input 1: core program-end flag (PC reached end address).
- `core_reset` output 1: active-high reset to the core.
- `core_en` output 1: core advance enable (PC/regfile/memory writes).
- `busy` output 1: high in RST, RUN and DRAIN.
- `done` output 1: run-complete handshake.
- `timeout` output 1: last run ended by the watchdog.
- `cycle_cnt` output CW: run-cycle count of the current or last run.

## Operation

- All outputs are registered. Reset values: `core_reset`=1, `core_en`=0, `busy`=0, `done`=0, `timeout`=0, `cycle_cnt`=0. The state after reset is IDLE.
- **IDLE**:
  - `core_reset`=1, `core_en`=0.
  - `req`=1 → RST. `cycle_cnt` and `timeout` are cleared on this transition.
- **RST**:
  - `core_reset`=1 for exactly `RST_CYCLES` cycles, then → RUN.
- **RUN**:
  - `core_reset`=0, `core_en`=1.
  - Each RUN cycle with `core_done`=0 increments `cycle_cnt`, saturating at all-ones.
  - `core_done`=1 → DRAIN, or → DONE if `DRAIN`=0. `cycle_cnt` is not incremented in that cycle.
- **DRAIN**:
  - `core_en`=0, `core_reset`=0, counter frozen.
  - Lasts `DRAIN` cycles, then → DONE.
- **DONE**:
  - `done`=1, `core_en`=0, `core_reset`=0 (the core's final state stays observable).
  - Held while `req`=1. `req`=0 → IDLE, and `done` falls on that transition.
- **Boundary conditions**:
  - `req` dropping during RST/RUN/DRAIN is ignored; the run completes.
  - A new run starts only from IDLE, so `req` must go low then high.
  - `reset` asserted in any state forces reset values immediately, independent of `clk`. The in-flight run is abandoned.
  - `core_done` in RST is ignored.
  - `core_done` and the watchdog limit in the same cycle: `core_done` wins and `timeout` stays 0.

## Timing

- `req` sampled high at edge k: RST occupies cycles k+1..k+RST_CYCLES, and RUN begins at k+RST_CYCLES+1.
- `core_done` sampled high at RUN edge m: DRAIN occupies m+1..m+DRAIN, and `done`=1 from m+DRAIN+1.
- `req` sampled low in DONE at edge n: `done`=0 and IDLE from n+1. The earliest restart samples `req` at n+1.
- `cycle_cnt` equals the number of RUN cycles with `core_done`=0. It is stable from DRAIN entry until the next run starts.

## Configuration

- `RUN_CTRL_WATCHDOG_EN` defined:
  - A RUN cycle with `core_done`=0 and `cycle_cnt`==TMO−1 increments the count to TMO and goes directly to DONE.
  - `timeout`=1 and DRAIN is skipped.
- Not defined:
  - No watchdog, and `timeout` is tied to 0.
  - RUN persists until `core_done`, with `cycle_cnt` saturating.

## Structure

- Shared package `run_ctrl_pkg`:
  - State enum `run_state_t` {IDLE, RST, RUN, DRAIN, DONE}.
  - Default constants for `RST_CYCLES`, `DRAIN` and `TMO`.
- One sub-module, `phase_timer`: a loadable down-counter with a zero flag, shared by the RST and DRAIN phases.
- `cycle_cnt` stays in `run_ctrl`.

## Test plan

1. **Basic run** (RST_CYCLES=4, DRAIN=2): `req` at edge 0, `core_done` at edge 15 → `core_reset` high through cycle 4, `core_en` high 5..15, `done` at 18, `cycle_cnt`=10.
2. **Handshake**: hold `req` after `done` for 5 cycles → `done` stays 1. Drop `req` → `done`=0 next cycle. Re-raise `req` → new run with `cycle_cnt` cleared to 0.
3. **Watchdog** (macro defined, TMO=20, `core_done` never asserted) → `done` and `timeout` both 1 with `cycle_cnt`=20. Same stimulus without the macro (CW=4) → no `done`, `cycle_cnt` saturates at 15.
4. **Simultaneous events** (macro defined, TMO=20, `core_done` in the RUN cycle with `cycle_cnt`=19) → `timeout`=0, DRAIN taken, `cycle_cnt`=19.
5. **Reset mid-run**: assert `reset` low mid-RUN, off-edge → all outputs reach reset values before the next edge. After release with `req`=1 → clean run as in scenario 1.
6. **Zero drain** (DRAIN=0, `core_done` on the first RUN cycle) → `done` the next cycle, `cycle_cnt`=0.
